// File: rtl/maj_pkg.sv
// Shared types and helpers for the majority vote sequencer.
// Holds the FSM state enum, N_OPS legality check and index width.
package maj_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int N_OPS_DEF = 3;
  localparam int IDX_W     = $clog2(N_OPS_DEF);

  function automatic bit n_ops_ok(input int n);
    return (n >= 3) && (n <= 7) && (n % 2 == 1);
  endfunction

endpackage

// File: rtl/majority_n_core.sv
// Combinational bitwise majority of N_OPS packed operands.
// Ports: operands (N_OPS*WIDTH, slot k at [k*WIDTH +: WIDTH]),
// majority (WIDTH); unanimous (WIDTH) only with MAJ_UNANIMOUS_EN.
module majority_n_core #(
  parameter int WIDTH = 8,
  parameter int N_OPS = 3
) (
  input  logic [N_OPS*WIDTH-1:0] operands,
  output logic [WIDTH-1:0]       majority
`ifdef MAJ_UNANIMOUS_EN
  ,
  output logic [WIDTH-1:0]       unanimous
`endif
);

  int ones;

  always_comb begin
    ones     = 0;
    majority = '0;
`ifdef MAJ_UNANIMOUS_EN
    unanimous = '0;
`endif
    for (int b = 0; b < WIDTH; b++) begin
      ones = 0;
      for (int k = 0; k < N_OPS; k++) begin
        ones = ones + int'(operands[k*WIDTH+b]);
      end
      majority[b] = (ones > N_OPS / 2);
`ifdef MAJ_UNANIMOUS_EN
      unanimous[b] = (ones == 0) || (ones == N_OPS);
`endif
    end
  end

endmodule

// File: rtl/majority_vote_sequencer.sv
// Collects N_OPS operands (valid/ready), registers their bitwise
// majority and hands it off (valid/ready); flush + result counter.
// Ports: clk, rst (sync, high), flush, in_valid/in_ready/in_data,
// out_valid/out_ready/out_data, op_idx, result_cnt.
// Option MAJ_UNANIMOUS_EN adds out_unanimous (all-agree mask).
module majority_vote_sequencer
  import maj_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_OPS = 3,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(N_OPS)-1:0] op_idx,
  output logic [CNT_W-1:0]         result_cnt
`ifdef MAJ_UNANIMOUS_EN
  ,
  output logic [WIDTH-1:0]         out_unanimous
`endif
);

  localparam int IW = $clog2(N_OPS);

  if (!n_ops_ok(N_OPS)) begin : g_bad_n_ops
    $error("N_OPS must be odd and within 3..7");
  end

  state_t state_q, state_d;
  logic   accept, compute, handoff, last;

  logic [WIDTH-1:0]       ops_q [N_OPS];
  logic [N_OPS*WIDTH-1:0] ops_packed;
  logic [WIDTH-1:0]       maj_c;
`ifdef MAJ_UNANIMOUS_EN
  logic [WIDTH-1:0]       unan_c;
`endif

  assign last = (op_idx == IW'(N_OPS - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  // Flush wins over any accept/compute/hand-off in the same cycle.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    compute  = 1'b0;
    handoff  = 1'b0;
    unique case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        accept   = in_valid && !flush;
        if (accept && last) state_d = COMPUTE;
      end
      COMPUTE: begin
        compute = !flush;
        state_d = HOLD;
      end
      HOLD: begin
        handoff = out_valid && out_ready && !flush;
        if (handoff) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    if (flush) state_d = COLLECT;
  end

  always_comb begin
    ops_packed = '0;
    for (int k = 0; k < N_OPS; k++) begin
      ops_packed[k*WIDTH +: WIDTH] = ops_q[k];
    end
  end

  majority_n_core #(
    .WIDTH (WIDTH),
    .N_OPS (N_OPS)
  ) u_core (
    .operands  (ops_packed),
    .majority  (maj_c)
`ifdef MAJ_UNANIMOUS_EN
    ,
    .unanimous (unan_c)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      op_idx     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      result_cnt <= '0;
`ifdef MAJ_UNANIMOUS_EN
      out_unanimous <= '0;
`endif
      for (int k = 0; k < N_OPS; k++) ops_q[k] <= '0;
    end else if (flush) begin
      op_idx    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        ops_q[op_idx] <= in_data;
        op_idx        <= last ? '0 : op_idx + 1'b1;
      end
      if (compute) begin
        out_data  <= maj_c;
        out_valid <= 1'b1;
`ifdef MAJ_UNANIMOUS_EN
        out_unanimous <= unan_c;
`endif
      end
      if (handoff) begin
        out_valid  <= 1'b0;
        result_cnt <= result_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_majority_vote_sequencer.sv
// Self-checking bench for majority_vote_sequencer (WIDTH=8, N_OPS=3).
// Directed steps followed by a randomized run against a queue model.
module tb_majority_vote_sequencer;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic          in_ready, out_valid;
  logic [1:0]    op_idx;
  logic [CW-1:0] result_cnt;
`ifdef MAJ_UNANIMOUS_EN
  logic [W-1:0]  out_unanimous;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  majority_vote_sequencer #(
    .WIDTH (W),
    .N_OPS (N),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .op_idx     (op_idx),
    .result_cnt (result_cnt)
`ifdef MAJ_UNANIMOUS_EN
    ,
    .out_unanimous (out_unanimous)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    chk("send_rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Reference: bit b is set when more than half the operands set it.
  function automatic logic [W-1:0] ref_maj(input logic [W-1:0] q[$]);
    logic [W-1:0] r;
    int cnt;
    r = '0;
    for (int b = 0; b < W; b++) begin
      cnt = 0;
      foreach (q[i]) cnt += int'(q[i][b]);
      r[b] = (2 * cnt > q.size());
    end
    return r;
  endfunction

  logic [W-1:0]  part[$];
  logic [W-1:0]  expq[$];
  logic [W-1:0]  ops[$];
  logic [CW-1:0] ecnt;
  logic          acc, hs;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_op_idx", 32'(op_idx), 32'd0);
    chk("rst_cnt", 32'(result_cnt), 32'd0);

    // Basic vote, consumer always ready.
    out_ready = 1'b1;
    send(8'hF0); send(8'hCC); send(8'hAA);
    chk("t1_cmp_valid", 32'(out_valid), 32'd0);
    chk("t1_cmp_rdy", 32'(in_ready), 32'd0);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'hE8);
    ops = {8'hF0, 8'hCC, 8'hAA};
    chk("t1_model", 32'(out_data), 32'(ref_maj(ops)));
`ifdef MAJ_UNANIMOUS_EN
    chk("t1_unan", 32'(out_unanimous), 32'h81);
`endif
    tick();
    chk("t1_done_valid", 32'(out_valid), 32'd0);
    chk("t1_cnt", 32'(result_cnt), 32'd1);
    chk("t1_rdy_back", 32'(in_ready), 32'd1);

    // Back-pressure: result held for 5 cycles.
    out_ready = 1'b0;
    send(8'hF0); send(8'hCC); send(8'hAA);
    tick();
    repeat (5) begin
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_data", 32'(out_data), 32'hE8);
      chk("t2_rdy", 32'(in_ready), 32'd0);
      chk("t2_cnt", 32'(result_cnt), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t2_cnt_inc", 32'(result_cnt), 32'd2);
    chk("t2_valid_off", 32'(out_valid), 32'd0);

    // Flush on the third operand beat.
    send(8'hFF); send(8'h00);
    chk("t3_idx2", 32'(op_idx), 32'd2);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3_idx0", 32'(op_idx), 32'd0);
    chk("t3_rdy", 32'(in_ready), 32'd1);
    chk("t3_valid", 32'(out_valid), 32'd0);
    tick(); tick();
    chk("t3_no_result", 32'(out_valid), 32'd0);
    chk("t3_cnt", 32'(result_cnt), 32'd2);
    send(8'h0F); send(8'h0F); send(8'h00);
    tick();
    chk("t3_valid2", 32'(out_valid), 32'd1);
    chk("t3_data2", 32'(out_data), 32'h0F);
    tick();
    chk("t3_cnt2", 32'(result_cnt), 32'd3);

    // Flush in HOLD beats a simultaneous hand-off.
    out_ready = 1'b0;
    send(8'h3C); send(8'h3C); send(8'hFF);
    tick();
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_data", 32'(out_data), 32'h3C);
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_valid_off", 32'(out_valid), 32'd0);
    chk("t4_cnt", 32'(result_cnt), 32'd3);
    chk("t4_rdy", 32'(in_ready), 32'd1);

    // 256 votes wrap the counter, then reset mid-collection.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int v = 0; v < 256; v++) begin
      if (v == 255) chk("t5_cnt255", 32'(result_cnt), 32'd255);
      send(8'h5A); send(8'h5A); send(8'h5A);
      tick(); tick();
    end
    chk("t5_wrap", 32'(result_cnt), 32'd0);
    chk("t5_data", 32'(out_data), 32'h5A);
    send(8'h5A); send(8'h5A);
    chk("t5_idx2", 32'(op_idx), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_idx", 32'(op_idx), 32'd0);
    chk("t5_rst_rdy", 32'(in_ready), 32'd1);
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_data", 32'(out_data), 32'h0);
    chk("t5_rst_cnt", 32'(result_cnt), 32'd0);
`ifdef MAJ_UNANIMOUS_EN
    chk("t5_rst_unan", 32'(out_unanimous), 32'h0);
`endif

    // Randomized traffic against the queue model.
    ecnt = '0;
    part.delete();
    expq.delete();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 9) < 5);
      chk("rnd_rdy", 32'(in_ready), 32'(expq.size() == 0));
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (out_valid) chk("rnd_spur", 32'(expq.size() != 0), 32'd1);
      if (hs) begin
        if (expq.size() != 0)
          chk("rnd_data", 32'(out_data), 32'(expq.pop_front()));
        ecnt = ecnt + 1'b1;
      end
      if (acc) begin
        part.push_back(in_data);
        if (part.size() == N) begin
          expq.push_back(ref_maj(part));
          part.delete();
        end
      end
      tick();
      chk("rnd_cnt", 32'(result_cnt), 32'(ecnt));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8 && expq.size() > 0; k++) begin
      if (out_valid) begin
        chk("drain_data", 32'(out_data), 32'(expq.pop_front()));
        ecnt = ecnt + 1'b1;
      end
      tick();
    end
    chk("drain_empty", 32'(expq.size()), 32'd0);
    chk("drain_cnt", 32'(result_cnt), 32'(ecnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
